// File: rtl/axi_rb.sv
// Single-burst AXI4 read master: one AR request, then every R beat is forwarded
// straight into a FIFO write port, with the FIFO's ready used as R backpressure.
//
// state | meaning
// IDLE  | waiting for start; burst_addr/burst_len latched on start
// ADDR  | AR request presented until arready
// DATA  | R beats pass through to the FIFO; counter tracks the latched length
// DONE  | one-cycle valid pulse, then back to IDLE
module axi_rb #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] burst_addr,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  output logic [ADDR_WIDTH-1:0] s_axi_araddr,
  output logic [LEN_WIDTH-1:0]  s_axi_arlen,
  output logic [2:0]            s_axi_arsize,
  output logic [1:0]            s_axi_arburst,
  output logic                  s_axi_arvalid,
  input  logic                  s_axi_arready,
  input  logic [DATA_WIDTH-1:0] s_axi_rdata,
  input  logic [1:0]            s_axi_rresp,
  input  logic                  s_axi_rlast,
  input  logic                  s_axi_rvalid,
  output logic                  s_axi_rready,
  output logic [DATA_WIDTH-1:0] fifo_in_data,
  output logic                  fifo_write_valid,
  input  logic                  fifo_write_ready,
  output logic                  busy,
  output logic                  error,
  output logic                  valid
);

  localparam logic [2:0] ARSIZE = 3'($clog2(DATA_WIDTH / 8));

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  beat;
  logic                  last_beat;

  assign beat      = (state_q == S_DATA) && s_axi_rvalid && fifo_write_ready;
  // Equality is checked before the increment, so len = all-ones never wraps early.
  assign last_beat = (cnt_q == len_q);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ADDR;
          addr_d  = burst_addr;
          len_d   = burst_len;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      S_ADDR: begin
        if (s_axi_arready) state_d = S_DATA;
      end
      S_DATA: begin
        if (beat) begin
          // rlast is only cross-checked; the latched length decides when to stop.
          if ((s_axi_rresp != 2'b00) || (s_axi_rlast != last_beat)) err_d = 1'b1;
          if (last_beat) state_d = S_DONE;
          else           cnt_d   = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign s_axi_araddr     = addr_q;
  assign s_axi_arlen      = len_q;
  assign s_axi_arsize     = ARSIZE;
  assign s_axi_arburst    = 2'b01;
  assign s_axi_arvalid    = (state_q == S_ADDR);
  assign s_axi_rready     = (state_q == S_DATA) && fifo_write_ready;
  assign fifo_write_valid = (state_q == S_DATA) && s_axi_rvalid;
  assign fifo_in_data     = s_axi_rdata;
  assign busy             = (state_q == S_ADDR) || (state_q == S_DATA);
  assign valid            = (state_q == S_DONE);
  assign error            = err_q;

endmodule

// File: tb/tb_axi_rb.sv
// Bench for axi_rb: drives the AR/R slave and FIFO sides, compares pushed data,
// error flag and done pulse against a beat-list reference model.
module tb_axi_rb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] burst_addr = '0;
  logic [7:0]  burst_len = '0;
  logic [15:0] s_axi_araddr;
  logic [7:0]  s_axi_arlen;
  logic [2:0]  s_axi_arsize;
  logic [1:0]  s_axi_arburst;
  logic        s_axi_arvalid;
  logic        s_axi_arready = 1'b0;
  logic [31:0] s_axi_rdata = '0;
  logic [1:0]  s_axi_rresp = '0;
  logic        s_axi_rlast = 1'b0;
  logic        s_axi_rvalid = 1'b0;
  logic        s_axi_rready;
  logic [31:0] fifo_in_data;
  logic        fifo_write_valid;
  logic        fifo_write_ready = 1'b0;
  logic        busy;
  logic        error;
  logic        valid;

  always #5 clk = ~clk;

  axi_rb dut (
    .clk(clk), .rst(rst), .start(start), .burst_addr(burst_addr), .burst_len(burst_len),
    .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize),
    .s_axi_arburst(s_axi_arburst), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .fifo_in_data(fifo_in_data),
    .fifo_write_valid(fifo_write_valid), .fifo_write_ready(fifo_write_ready),
    .busy(busy), .error(error), .valid(valid)
  );

  int checks = 0;
  int errors = 0;

  // Reference beat list for the burst about to run.
  logic [31:0] beat_data[$];
  logic [1:0]  beat_resp[$];
  logic        beat_last[$];
  logic [31:0] pushed[$];

  int obs_ar_cycles, obs_ar_bad, obs_mirror_bad, obs_valid_cnt, obs_push_at_valid;
  logic obs_err_at_start, obs_err_final, obs_valid_after, obs_busy_after, obs_timeout;

  task automatic gen_beats(input int len, input int bad_resp_at, input int early_last_at,
                           input bit drop_last);
    beat_data.delete(); beat_resp.delete(); beat_last.delete();
    for (int i = 0; i <= len; i++) begin
      beat_data.push_back($urandom);
      beat_resp.push_back((i == bad_resp_at) ? 2'b10 : 2'b00);
      if (i == len) beat_last.push_back(!drop_last);
      else          beat_last.push_back(i == early_last_at);
    end
  endtask

  function automatic logic exp_error(input int len);
    for (int i = 0; i <= len; i++)
      if (beat_resp[i] != 2'b00 || beat_last[i] != (i == len)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int data_mismatches(input int len);
    int m = 0;
    for (int i = 0; i <= len; i++)
      if (i >= pushed.size() || pushed[i] !== beat_data[i]) m++;
    return m;
  endfunction

  // Acts as AXI slave and FIFO sink for one burst; stops one cycle after the done pulse.
  task automatic do_burst(input logic [15:0] a, input logic [7:0] l, input int ar_delay,
                          input int rdy_mode, input bit hold);
    int  b = 0;
    int  n = int'(l) + 1;
    bit  done = 0;
    pushed.delete();
    obs_ar_cycles = 0; obs_ar_bad = 0; obs_mirror_bad = 0; obs_valid_cnt = 0;
    obs_push_at_valid = -1; obs_err_final = 1'bx; obs_timeout = 0;
    @(negedge clk);
    start = 1'b1; burst_addr = a; burst_len = l;
    @(negedge clk);
    if (!hold) start = 1'b0;
    obs_err_at_start = error;
    for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (valid) begin
        obs_valid_cnt++;
        obs_push_at_valid = pushed.size();
        obs_err_final = error;
        done = 1;
        s_axi_rvalid = 1'b0; s_axi_arready = 1'b0;
      end else begin
        if (s_axi_arvalid) begin
          obs_ar_cycles++;
          if (s_axi_araddr !== a || s_axi_arlen !== l) obs_ar_bad++;
          s_axi_arready = (obs_ar_cycles > ar_delay);
        end else s_axi_arready = 1'b0;
        case (rdy_mode)
          0:       fifo_write_ready = 1'b1;
          1:       fifo_write_ready = cyc[0];
          default: fifo_write_ready = 1'($urandom_range(0, 1));
        endcase
        if (b < n) begin
          s_axi_rvalid = 1'b1; s_axi_rdata = beat_data[b];
          s_axi_rresp = beat_resp[b]; s_axi_rlast = beat_last[b];
        end else begin
          s_axi_rvalid = 1'b0; s_axi_rdata = $urandom;
          s_axi_rresp = 2'b00; s_axi_rlast = 1'b0;
        end
        #1;
        if (busy && !s_axi_arvalid) begin
          if (s_axi_rready !== fifo_write_ready || fifo_write_valid !== s_axi_rvalid)
            obs_mirror_bad++;
        end else if (s_axi_rready !== 1'b0 || fifo_write_valid !== 1'b0) obs_mirror_bad++;
        if (fifo_write_valid && fifo_write_ready) begin
          pushed.push_back(fifo_in_data);
          b++;
        end
      end
    end
    if (!done) obs_timeout = 1;
    @(negedge clk);
    obs_valid_after = valid;
    obs_busy_after = busy;
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({s_axi_arvalid, s_axi_rready, fifo_write_valid, busy, valid, error} !== 6'b0) begin
      errors++; $display("FAIL reset_outputs: got %b exp 000000",
        {s_axi_arvalid, s_axi_rready, fifo_write_valid, busy, valid, error});
    end
    checks++;
    if (s_axi_araddr !== 16'h0 || s_axi_arlen !== 8'h0) begin
      errors++; $display("FAIL reset_regs: addr %h len %h exp 0 0", s_axi_araddr, s_axi_arlen);
    end
    checks++;
    if (s_axi_arsize !== 3'd2 || s_axi_arburst !== 2'b01) begin
      errors++; $display("FAIL ar_consts: size %0d burst %b exp 2 01", s_axi_arsize, s_axi_arburst);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_single;
    gen_beats(0, -1, -1, 0);
    beat_data[0] = 32'hDEADBEEF;
    do_burst(16'h0040, 8'd0, 0, 0, 0);
    checks++;
    if (obs_ar_cycles !== 1 || obs_ar_bad !== 0) begin
      errors++; $display("FAIL single_ar: cycles %0d bad %0d exp 1 0", obs_ar_cycles, obs_ar_bad);
    end
    checks++;
    if (pushed.size() !== 1 || data_mismatches(0) !== 0) begin
      errors++; $display("FAIL single_data: got %0d beats first %h exp 1 deadbeef",
                         pushed.size(), (pushed.size() > 0) ? pushed[0] : 32'h0);
    end
    checks++;
    if (obs_valid_cnt !== 1 || obs_err_final !== 1'b0 || obs_timeout !== 1'b0) begin
      errors++; $display("FAIL single_done: valid %0d err %b timeout %b exp 1 0 0",
                         obs_valid_cnt, obs_err_final, obs_timeout);
    end
    checks++;
    if (obs_valid_after !== 1'b0 || obs_busy_after !== 1'b0) begin
      errors++; $display("FAIL single_pulse: valid %b busy %b after done exp 0 0",
                         obs_valid_after, obs_busy_after);
    end
  endtask

  task automatic test_ar_delay;
    gen_beats(3, -1, -1, 0);
    for (int i = 0; i < 4; i++) beat_data[i] = 32'(i + 1);
    do_burst(16'h1230, 8'd3, 3, 0, 0);
    checks++;
    if (obs_ar_cycles !== 4 || obs_ar_bad !== 0) begin
      errors++; $display("FAIL ar_delay: cycles %0d bad %0d exp 4 0", obs_ar_cycles, obs_ar_bad);
    end
    checks++;
    if (pushed.size() !== 4 || data_mismatches(3) !== 0) begin
      errors++; $display("FAIL ar_delay_data: beats %0d mism %0d exp 4 0", pushed.size(), data_mismatches(3));
    end
    checks++;
    if (obs_push_at_valid !== 4 || obs_valid_cnt !== 1) begin
      errors++; $display("FAIL ar_delay_valid: pushes at valid %0d count %0d exp 4 1",
                         obs_push_at_valid, obs_valid_cnt);
    end
  endtask

  task automatic test_backpressure;
    gen_beats(7, -1, -1, 0);
    do_burst(16'h2000, 8'd7, 0, 1, 0);
    checks++;
    if (obs_mirror_bad !== 0) begin
      errors++; $display("FAIL bp_mirror: %0d bad cycles exp 0", obs_mirror_bad);
    end
    checks++;
    if (pushed.size() !== 8 || data_mismatches(7) !== 0) begin
      errors++; $display("FAIL bp_data: beats %0d mism %0d exp 8 0", pushed.size(), data_mismatches(7));
    end
    checks++;
    if (obs_err_final !== 1'b0) begin
      errors++; $display("FAIL bp_error: got %b exp 0", obs_err_final);
    end
  endtask

  task automatic test_error;
    gen_beats(3, 1, -1, 0);
    do_burst(16'h3000, 8'd3, 1, 0, 0);
    checks++;
    if (obs_err_final !== exp_error(3) || pushed.size() !== 4) begin
      errors++; $display("FAIL err_set: err %b beats %0d exp %b 4", obs_err_final, pushed.size(), exp_error(3));
    end
    checks++;
    if (error !== 1'b1) begin
      errors++; $display("FAIL err_sticky: got %b exp 1", error);
    end
    gen_beats(3, -1, -1, 0);
    do_burst(16'h3100, 8'd3, 0, 2, 0);
    checks++;
    if (obs_err_at_start !== 1'b0) begin
      errors++; $display("FAIL err_clear: got %b exp 0", obs_err_at_start);
    end
    checks++;
    if (obs_err_final !== 1'b0 || data_mismatches(3) !== 0) begin
      errors++; $display("FAIL err_clean: err %b mism %0d exp 0 0", obs_err_final, data_mismatches(3));
    end
  endtask

  task automatic test_long;
    gen_beats(255, -1, -1, 1);
    do_burst(16'h8000, 8'd255, 2, 2, 0);
    checks++;
    if (pushed.size() !== 256 || data_mismatches(255) !== 0) begin
      errors++; $display("FAIL long_data: beats %0d mism %0d exp 256 0", pushed.size(), data_mismatches(255));
    end
    checks++;
    if (obs_push_at_valid !== 256 || obs_valid_cnt !== 1 || obs_timeout !== 1'b0) begin
      errors++; $display("FAIL long_valid: pushes at valid %0d count %0d timeout %b exp 256 1 0",
                         obs_push_at_valid, obs_valid_cnt, obs_timeout);
    end
    checks++;
    if (obs_err_final !== exp_error(255)) begin
      errors++; $display("FAIL long_nolast: err %b exp %b", obs_err_final, exp_error(255));
    end
  endtask

  task automatic test_random;
    for (int t = 0; t < 8; t++) begin
      int len  = int'($urandom_range(0, 15));
      int bad  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, len)) : -1;
      int earl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len)) : -1;
      bit drop = ($urandom_range(0, 3) == 0);
      gen_beats(len, bad, earl, drop);
      do_burst(16'($urandom), 8'(len), int'($urandom_range(0, 3)), 2, 0);
      checks++;
      if (pushed.size() !== len + 1 || data_mismatches(len) !== 0 || obs_ar_bad !== 0) begin
        errors++; $display("FAIL rand_data[%0d]: beats %0d mism %0d arbad %0d exp %0d 0 0",
                           t, pushed.size(), data_mismatches(len), obs_ar_bad, len + 1);
      end
      checks++;
      if (obs_err_final !== exp_error(len) || obs_push_at_valid !== len + 1 || obs_mirror_bad !== 0) begin
        errors++; $display("FAIL rand_status[%0d]: err %b pushes %0d mirror %0d exp %b %0d 0",
                           t, obs_err_final, obs_push_at_valid, obs_mirror_bad, exp_error(len), len + 1);
      end
    end
  endtask

  task automatic test_back_to_back;
    gen_beats(1, -1, -1, 0);
    do_burst(16'h0100, 8'd1, 0, 0, 1);
    burst_addr = 16'h0200;
    @(negedge clk);
    checks++;
    if (s_axi_arvalid !== 1'b1 || s_axi_araddr !== 16'h0200) begin
      errors++; $display("FAIL b2b_retrigger: arvalid %b addr %h exp 1 0200", s_axi_arvalid, s_axi_araddr);
    end
    start = 1'b0;
    rst = 1'b1; #1; rst = 1'b0;
  endtask

  task automatic test_reset_mid;
    gen_beats(7, 0, -1, 0);
    @(negedge clk); start = 1'b1; burst_addr = 16'h4440; burst_len = 8'd7;
    @(negedge clk); start = 1'b0; s_axi_arready = 1'b1;
    fifo_write_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); s_axi_arready = 1'b0;
      s_axi_rvalid = 1'b1; s_axi_rdata = beat_data[i];
      s_axi_rresp = beat_resp[i]; s_axi_rlast = beat_last[i];
    end
    @(negedge clk); s_axi_rvalid = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    checks++;
    if (s_axi_arvalid !== 1'b0 || busy !== 1'b1 || error !== 1'b1) begin
      errors++; $display("FAIL mid_start: arvalid %b busy %b err %b exp 0 1 1", s_axi_arvalid, busy, error);
    end
    s_axi_rvalid = 1'b1;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({s_axi_arvalid, s_axi_rready, fifo_write_valid, busy, valid, error} !== 6'b0) begin
      errors++; $display("FAIL mid_reset_async: got %b exp 000000",
        {s_axi_arvalid, s_axi_rready, fifo_write_valid, busy, valid, error});
    end
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || s_axi_arvalid !== 1'b0 || fifo_write_valid !== 1'b0) begin
        errors++; $display("FAIL mid_idle[%0d]: busy %b arvalid %b fwv %b exp 0 0 0",
                           i, busy, s_axi_arvalid, fifo_write_valid);
      end
    end
    s_axi_rvalid = 1'b0;
  endtask

  initial begin
    test_reset;
    test_single;
    test_ar_delay;
    test_backpressure;
    test_error;
    test_long;
    test_random;
    test_back_to_back;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
